// File: rtl/mem_pkg.sv
// Shared definitions for the memory-stage access controller: MIPS load/store
// opcodes, data-cache size encodings and FSM state encodings.
package mem_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // State encodings kept as plain constants so netlists and older tools see
    // stable values; the enum mirrors them for debug viewers.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_REQ   = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_REQ   = ST_REQ,
        S_WAIT  = ST_WAIT,
        S_DONE  = ST_DONE,
        S_DRAIN = ST_DRAIN
    } mem_state_e;

    // Access size from opcode; anything not byte/half is treated as a word.
    function automatic logic [1:0] op_size(input logic [5:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: op_size = SIZE_BYTE;
            OP_LH, OP_LHU, OP_SH: op_size = SIZE_HALF;
            default:              op_size = SIZE_WORD;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Data-cache request/response bus (req/addr_ok/data_ok handshake).
// master: the access controller; slave: the data cache.
interface mem_access_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              data_req;
    logic              data_wr;
    logic [1:0]        data_size;
    logic [ADDR_W-1:0] data_addr;
    logic [3:0]        data_wstrb;
    logic [DATA_W-1:0] data_wdata;
    logic              data_uncached;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [DATA_W-1:0] data_rdata;

    modport master (
        output data_req, data_wr, data_size, data_addr, data_wstrb,
               data_wdata, data_uncached,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wstrb,
               data_wdata, data_uncached,
        output data_addr_ok, data_data_ok, data_rdata
    );
endinterface

// File: rtl/mem_data_align.sv
// Lane handling for loads and stores: access size, byte strobes and
// replicated store data on the way out; lane extraction and sign/zero
// extension of the returned word on the way in. Purely combinational.
module mem_data_align
    import mem_pkg::*;
(
    input  logic [5:0]  op,
    input  logic [1:0]  lane,
    input  logic [31:0] wdata_in,
    input  logic [31:0] rdata_in,
    output logic [1:0]  size,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata_out,
    output logic [31:0] rdata_out
);

    logic [31:0] shifted;

    // Store side: strobes follow the low address bits, data is replicated
    // across every lane so the cache can pick whichever lane it writes.
    always_comb begin
        size      = op_size(op);
        wstrb     = 4'b1111;
        wdata_out = wdata_in;
        case (size)
            SIZE_BYTE: begin
                wstrb     = 4'b0001 << lane;
                wdata_out = {4{wdata_in[7:0]}};
            end
            SIZE_HALF: begin
                wstrb     = 4'b0011 << lane;
                wdata_out = {2{wdata_in[15:0]}};
            end
            default: begin
                wstrb     = 4'b1111;
                wdata_out = wdata_in;
            end
        endcase
    end

    // Load side: bring the addressed lane down to bit 0, then extend.
    always_comb begin
        shifted = rdata_in >> {lane, 3'b000};
        case (op)
            OP_LB:   rdata_out = {{24{shifted[7]}}, shifted[7:0]};
            OP_LBU:  rdata_out = {24'd0, shifted[7:0]};
            OP_LH:   rdata_out = {{16{shifted[15]}}, shifted[15:0]};
            OP_LHU:  rdata_out = {16'd0, shifted[15:0]};
            default: rdata_out = rdata_in;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage data-access controller. Issues one cache access per M-stage
// instruction, stalls the pipe until it completes, and drains a response
// that is still owed when the instruction is flushed.
// Optional build macro MEM_ACCESS_STAT_EN adds load/store/stall counters;
// without it the stat_* ports are tied to zero.
//
//  state | meaning
//  IDLE  | no access outstanding; request driven combinationally on start
//  REQ   | request presented, waiting for addr_ok
//  WAIT  | request accepted, waiting for data_ok
//  DONE  | result held in mem_rdata until the instruction leaves M
//  DRAIN | instruction flushed, swallowing the response still owed
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int STAT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              M_mem_en,
    input  logic              M_mem_ren,
    input  logic              M_mem_wen,
    input  logic [5:0]        M_mem_op,
    input  logic [ADDR_W-1:0] M_mem_addr,
    input  logic [DATA_W-1:0] M_mem_wdata,
    input  logic [ADDR_W-1:0] M_mem_pa,
    input  logic              M_mem_uncached,
    input  logic              M_except_in,
    input  logic              M_flush,
    input  logic              M_advance,
    mem_access_ctrl_if.master bus,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_stall,
    output logic              mem_adel,
    output logic              mem_ades,
    output logic [STAT_W-1:0] stat_load_cnt,
    output logic [STAT_W-1:0] stat_store_cnt,
    output logic [STAT_W-1:0] stat_stall_cnt
);

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [1:0]        size;
    logic [3:0]        wstrb_raw;
    logic [DATA_W-1:0] wdata_al;
    logic [DATA_W-1:0] rdata_ext;
    logic              misalign;
    logic              start;
    logic              capture;
    logic              unused_addr;

    // Only the low address bits matter here; the rest travel via M_mem_pa.
    assign unused_addr = ^M_mem_addr[ADDR_W-1:2];

    mem_data_align u_align (
        .op        (M_mem_op),
        .lane      (M_mem_addr[1:0]),
        .wdata_in  (M_mem_wdata),
        .rdata_in  (bus.data_rdata),
        .size      (size),
        .wstrb     (wstrb_raw),
        .wdata_out (wdata_al),
        .rdata_out (rdata_ext)
    );

    assign misalign = ((size == SIZE_HALF) && M_mem_addr[0]) ||
                      ((size == SIZE_WORD) && (M_mem_addr[1:0] != 2'b00));
    assign start    = M_mem_en && !M_except_in && !misalign && !M_flush;
    assign mem_adel = M_mem_en && M_mem_ren && misalign;
    assign mem_ades = M_mem_en && M_mem_wen && misalign;

    // Request fields come straight from the M stage; the stall keeps them
    // stable for as long as the request is outstanding.
    assign bus.data_req      = ((state == ST_IDLE) && start) || (state == ST_REQ);
    assign bus.data_wr       = M_mem_wen;
    assign bus.data_size     = size;
    assign bus.data_addr     = M_mem_pa;
    assign bus.data_wstrb    = M_mem_wen ? wstrb_raw : 4'b0000;
    assign bus.data_wdata    = wdata_al;
    assign bus.data_uncached = M_mem_uncached;

    assign mem_stall = ((state == ST_IDLE) && start) || (state == ST_REQ) ||
                       (state == ST_WAIT) || (state == ST_DRAIN);

    // Only loads overwrite the result register; a flushed response is dropped.
    assign capture = (state == ST_WAIT) && bus.data_data_ok && !M_flush && M_mem_ren;

    // Next-state logic. data_ok outside WAIT/DRAIN never belongs to us.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = bus.data_addr_ok ? ST_WAIT : ST_REQ;
            end
            ST_REQ: begin
                if (bus.data_addr_ok) state_nxt = M_flush ? ST_DRAIN : ST_WAIT;
                else if (M_flush)     state_nxt = ST_IDLE;
            end
            ST_WAIT: begin
                if (bus.data_data_ok) state_nxt = M_flush ? ST_IDLE : ST_DONE;
                else if (M_flush)     state_nxt = ST_DRAIN;
            end
            ST_DONE: begin
                if (M_advance || M_flush) state_nxt = ST_IDLE;
            end
            ST_DRAIN: begin
                if (bus.data_data_ok) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register and registered load result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            mem_rdata <= '0;
        end else begin
            state <= state_nxt;
            if (capture) mem_rdata <= rdata_ext;
        end
    end

`ifdef MEM_ACCESS_STAT_EN
    logic resp_in_wait;
    assign resp_in_wait = (state == ST_WAIT) && bus.data_data_ok;

    // Completion and stall statistics; counters wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_load_cnt  <= '0;
            stat_store_cnt <= '0;
            stat_stall_cnt <= '0;
        end else begin
            if (resp_in_wait && M_mem_ren) stat_load_cnt  <= stat_load_cnt + 1'b1;
            if (resp_in_wait && M_mem_wen) stat_store_cnt <= stat_store_cnt + 1'b1;
            if (mem_stall)                 stat_stall_cnt <= stat_stall_cnt + 1'b1;
        end
    end
`else
    assign stat_load_cnt  = '0;
    assign stat_store_cnt = '0;
    assign stat_stall_cnt = '0;
`endif

endmodule
